multiword_adder_seq: RTL
========================

MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 4-bit nibbles per operand (legal range 2..16).
REQ-002 SHALL have derived constant OPW = 4*WORDS, the operand and sum width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin an addition.
REQ-006 SHALL have port a_in  input  OPW  operand A, unsigned or two's complement.
REQ-007 SHALL have port b_in  input  OPW  operand B.
REQ-008 SHALL have port cin_in  input  1  carry-in to nibble 0.
REQ-009 SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum_out  output  OPW  result, (a_in + b_in + cin_in) mod 2^OPW.
REQ-012 SHALL have port cout_out  output  1  unsigned carry-out of the MSB nibble.
REQ-013 SHALL have port ovf_out  output  1  two's-complement overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, ADD and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, latching a_in, b_in and cin_in on that edge and entering ADD with nibble index 0.
REQ-016 SHALL ignore start while in ADD, with no effect on the operation in flight or its result.
REQ-017 SHALL, in each ADD cycle, add nibble k of A and B plus the carry register through a 4-bit ripple-carry adder.
REQ-018 SHALL, in each ADD cycle, write the 4-bit sum into sum nibble k and store the adder's carry-out in the carry register.
REQ-019 SHALL load the carry register from the latched cin_in for nibble 0.
REQ-020 SHALL process exactly WORDS nibbles in ADD, LSB nibble first, and then enter DONE.
REQ-021 SHALL hold the nibble index, sized to clog2(WORDS), without wrap-around during an operation.
REQ-022 SHALL set ovf_out on the final nibble to (A[OPW-1]==B[OPW-1]) && (sum[OPW-1]!=A[OPW-1]).
REQ-023 SHALL assert done for exactly one cycle, in DONE, and return to IDLE on the next edge unless start is high.
REQ-024 SHALL, with start sampled at edge T, raise busy from T to T+WORDS and raise done in the cycle after edge T+WORDS; latency is WORDS+1 cycles.
REQ-025 SHALL hold busy high in ADD only, allowing back-to-back operations when start is held in DONE.
REQ-026 SHALL keep sum_out, cout_out and ovf_out stable from done until the next accepted start.
REQ-027 SHALL leave sum_out, cout_out and ovf_out undefined for consumers while busy; consumers sample only on done.
REQ-028 SHALL produce results unaffected by changes to a_in, b_in or cin_in after the accepting edge.

Reset
REQ-029 SHALL, when rst_n is low at a rising edge, force state to IDLE, busy=0, done=0, sum_out=0, cout_out=0, ovf_out=0, index=0 and carry=0.
REQ-030 SHALL, when rst_n is low mid-operation, abort the operation with no done pulse, and ignore start in that same cycle.

Structure
REQ-031 SHALL place the state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and NIBBLE_W=4 in shared package multiword_adder_pkg.
REQ-032 SHALL instantiate the existing 4-bit ripple_carry_adder (a, b, cin, sum, cout) as its one sub-module, used once per cycle.

Verification
REQ-033 SHALL cover: WORDS=4, 0x1234 + 0x5678, cin=1 -> sum 0x68AD, cout 0, ovf 0, done in the 5th cycle after the start edge.
REQ-034 SHALL cover: 0xFFFF + 0x0001, cin=0 -> sum 0x0000, cout 1, ovf 0 (full carry ripple across all nibbles).
REQ-035 SHALL cover: 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1; and 0x8000 + 0x8000 -> sum 0x0000, cout 1, ovf 1.
REQ-036 SHALL cover: start pulsed with new operands during ADD -> ignored, first result unchanged, exactly one done pulse.
REQ-037 SHALL cover: rst_n low for one cycle at nibble 2 -> no done, all outputs 0, a following start completes normally.
REQ-038 SHALL cover: start held high through DONE -> second operation begins with no idle cycle, done pulses every 5 cycles.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial multiword adder.
package multiword_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder cell, reused once per cycle by the serial adder.
module ripple_carry_adder
    import multiword_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/multiword_adder_seq.sv
// Nibble-serial adder: one 4-bit ripple stage per cycle, LSB nibble first.
module multiword_adder_seq
    import multiword_adder_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int OPW   = NIBBLE_W * WORDS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] a_in,
    input  logic [OPW-1:0] b_in,
    input  logic           cin_in,
    output logic           busy,
    output logic           done,
    output logic [OPW-1:0] sum_out,
    output logic           cout_out,
    output logic           ovf_out
);

    localparam int            IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t state, state_nx;

    logic [OPW-1:0]      a_q, b_q, sum_q;
    logic [IW-1:0]       idx;
    logic                carry, cout_q, ovf_q;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic                c_nib;
    logic                accept;

    assign accept = start && (state != ADD);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (idx == LAST) state_nx = DONE;
            DONE:    state_nx = start ? ADD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ADD);
        done = (state == DONE);
    end

    always_comb begin
        a_nib = a_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
    end

    ripple_carry_adder u_rca (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= a_in;
            b_q   <= b_in;
            carry <= cin_in;
            idx   <= '0;
        end else if (state == ADD) begin
            sum_q[int'(idx) * NIBBLE_W +: NIBBLE_W] <= s_nib;
            carry <= c_nib;
            if (idx == LAST) begin
                // flags come from the MSB nibble only
                cout_q <= c_nib;
                ovf_q  <= (a_nib[NIBBLE_W-1] == b_nib[NIBBLE_W-1]) &&
                          (s_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign ovf_out  = ovf_q;

endmodule
